// File: rtl/acc_controller_param.sv
// Accumulator controller: fetches instructions by PC, executes ALU/branch ops on an
// accumulator and performs loads/stores through a req/ready + rvalid handshake.
module acc_controller_param #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 6,
    parameter int IMM_W  = 8,
    parameter int SH_W   = 5
) (
    input  logic                CLK,
    input  logic                RST,
    output logic [PC_W-1:0]     instr_addr,
    input  logic [8+IMM_W-1:0]  instr_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [IMM_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   acc,
    output logic                halted,
    output logic                exit_pulse
);
    localparam logic [7:0] OP_ADD  = 8'h01, OP_ADDI = 8'h02, OP_SUB  = 8'h03, OP_SUBI = 8'h04;
    localparam logic [7:0] OP_SHL  = 8'h05, OP_SHR  = 8'h06, OP_LD   = 8'h07, OP_LDI  = 8'h08;
    localparam logic [7:0] OP_ST   = 8'h09, OP_AND  = 8'h0A, OP_ANDI = 8'h0B, OP_OR   = 8'h0C;
    localparam logic [7:0] OP_ORI  = 8'h0D, OP_XOR  = 8'h0E, OP_XORI = 8'h0F, OP_JMP  = 8'h10;
    localparam logic [7:0] OP_BEZ  = 8'h11, OP_BNZ  = 8'h12, OP_EXIT = 8'h13, OP_BLZ  = 8'h14;

    typedef enum logic [1:0] {S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_HALT} state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_acc;
    logic [7:0]          r_op;
    logic [IMM_W-1:0]    r_imm;
    logic                r_mem_req;
    logic                r_mem_we;
    logic                r_halted;
    logic                r_exit;

    logic [7:0]          w_op;
    logic [IMM_W-1:0]    w_imm;
    logic [DATA_W-1:0]   w_imm_ext;
    logic [SH_W-1:0]     w_shamt;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_tgt;
    logic [DATA_W-1:0]   w_ld_result;

    assign w_op      = instr_data[8+IMM_W-1:IMM_W];
    assign w_imm     = instr_data[IMM_W-1:0];
    assign w_imm_ext = DATA_W'(w_imm);
    assign w_shamt   = instr_data[SH_W-1:0];
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_tgt     = w_imm[PC_W-1:0];

    // Combine the returning load word with the accumulator according to the latched op
    always_comb begin
        w_ld_result = mem_rdata;
        case (r_op)
            OP_ADD:  w_ld_result = r_acc + mem_rdata;
            OP_SUB:  w_ld_result = r_acc - mem_rdata;
            OP_AND:  w_ld_result = r_acc & mem_rdata;
            OP_OR:   w_ld_result = r_acc | mem_rdata;
            OP_XOR:  w_ld_result = r_acc ^ mem_rdata;
            default: w_ld_result = mem_rdata;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_EXEC;
            r_pc      <= '0;
            r_acc     <= '0;
            r_op      <= '0;
            r_imm     <= '0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_halted  <= 1'b0;
            r_exit    <= 1'b0;
        end else begin
            r_exit <= 1'b0;
            case (r_state)
                S_EXEC: begin
                    r_pc <= w_pc_inc;
                    case (w_op)
                        OP_ADDI: r_acc <= r_acc + w_imm_ext;
                        OP_SUBI: r_acc <= r_acc - w_imm_ext;
                        OP_LDI:  r_acc <= w_imm_ext;
                        OP_ANDI: r_acc <= r_acc & w_imm_ext;
                        OP_ORI:  r_acc <= r_acc | w_imm_ext;
                        OP_XORI: r_acc <= r_acc ^ w_imm_ext;
                        OP_SHL:  r_acc <= r_acc << w_shamt;
                        OP_SHR:  r_acc <= r_acc >> w_shamt;
                        OP_JMP:  r_pc <= w_tgt;
                        OP_BEZ:  if (r_acc == '0) r_pc <= w_tgt;
                        OP_BNZ:  if (r_acc != '0) r_pc <= w_tgt;
                        OP_BLZ:  if (r_acc[DATA_W-1]) r_pc <= w_tgt;
                        OP_EXIT: begin
                            r_pc     <= r_pc;
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                            r_exit   <= 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_LD, OP_AND, OP_OR, OP_XOR, OP_ST: begin
                            r_pc      <= r_pc;
                            r_op      <= w_op;
                            r_imm     <= w_imm;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= (w_op == OP_ST);
                            r_state   <= S_MEM_REQ;
                        end
                        default: ;
                    endcase
                end
                S_MEM_REQ: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_op == OP_ST) begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_EXEC;
                        end else begin
                            r_state <= S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rvalid) begin
                        r_acc   <= w_ld_result;
                        r_pc    <= w_pc_inc;
                        r_state <= S_EXEC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_addr = r_pc;
    assign acc        = r_acc;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_imm;
    assign mem_wdata  = r_acc;
    assign halted     = r_halted;
    assign exit_pulse = r_exit;

endmodule

// File: tb/tb_acc_controller_param.sv
// Bench for acc_controller_param: an ISA-level interpreter predicts memory transactions and the
// halt state; a monitor checks them as the DUT presents them, under random wait states.
module tb_acc_controller_param;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int IW = 8;
    localparam int SW = 5;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [PW-1:0]   instr_addr;
    logic [8+IW-1:0] instr_data;
    logic            mem_req, mem_we;
    logic [IW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready, mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic [DW-1:0]   acc;
    logic            halted, exit_pulse;

    acc_controller_param #(.DATA_W(DW), .PC_W(PW), .IMM_W(IW), .SH_W(SW)) dut (
        .CLK(CLK), .RST(RST), .instr_addr(instr_addr), .instr_data(instr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .acc(acc), .halted(halted), .exit_pulse(exit_pulse)
    );

    always #5 CLK = ~CLK;

    logic [8+IW-1:0] prog [0:63];
    logic [DW-1:0]   dmem [0:255];
    assign instr_data = prog[instr_addr];

    // responder-driven and manually-driven memory handshake, muxed
    logic            r_ready = 1'b0, r_rvalid = 1'b0;
    logic [DW-1:0]   r_rdata = '0;
    logic            man_en = 1'b0, man_ready = 1'b0, man_rvalid = 1'b0;
    logic [DW-1:0]   man_rdata = '0;
    int              cfg_rdy = -1, cfg_rv = -1;
    assign mem_ready  = man_en ? man_ready  : r_ready;
    assign mem_rvalid = man_en ? man_rvalid : r_rvalid;
    assign mem_rdata  = man_en ? man_rdata  : r_rdata;

    typedef struct { logic we; logic [IW-1:0] addr; logic [DW-1:0] wdata; } mem_t;
    typedef struct { logic [DW-1:0] acc; logic [PW-1:0] pc; } halt_t;
    mem_t  exp_mem[$];
    halt_t exp_halt[$];
    logic [DW-1:0] m_acc;
    logic [PW-1:0] m_pc;
    bit            m_ok;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Instruction-set interpreter: runs the program to EXIT and records the expected
    // memory requests and the final accumulator/PC.
    task automatic model_run();
        logic [DW-1:0] md [0:255];
        logic [DW-1:0] a, v;
        logic [7:0]    op, im;
        int            pc, nxt;
        md = dmem;
        a = '0; pc = 0; m_ok = 0;
        exp_mem.delete();
        exp_halt.delete();
        for (int s = 0; s < 150; s++) begin
            op  = prog[pc][15:8];
            im  = prog[pc][7:0];
            v   = DW'(im);
            nxt = (pc + 1) % 64;
            case (op)
                8'h02: a = a + v;
                8'h04: a = a - v;
                8'h08: a = v;
                8'h0B: a = a & v;
                8'h0D: a = a | v;
                8'h0F: a = a ^ v;
                8'h05: a = a << im[SW-1:0];
                8'h06: a = a >> im[SW-1:0];
                8'h10: nxt = im % 64;
                8'h11: if (a == 0) nxt = im % 64;
                8'h12: if (a != 0) nxt = im % 64;
                8'h14: if (a[DW-1]) nxt = im % 64;
                8'h13: begin
                    m_acc = a; m_pc = PW'(pc); m_ok = 1;
                    exp_halt.push_back('{acc: a, pc: PW'(pc)});
                    return;
                end
                8'h09: begin
                    exp_mem.push_back('{we: 1'b1, addr: im, wdata: a});
                    md[im] = a;
                end
                8'h01, 8'h03, 8'h07, 8'h0A, 8'h0C, 8'h0E: begin
                    exp_mem.push_back('{we: 1'b0, addr: im, wdata: a});
                    case (op)
                        8'h01:   a = a + md[im];
                        8'h03:   a = a - md[im];
                        8'h0A:   a = a & md[im];
                        8'h0C:   a = a | md[im];
                        8'h0E:   a = a ^ md[im];
                        default: a = md[im];
                    endcase
                end
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    // Memory responder: random ready stalls, random rvalid latency, spurious rvalid when idle
    int      rdy_cnt = -1, rv_cnt = 0;
    bit      pend = 0;
    logic [DW-1:0] rv_data;
    always begin
        @(negedge CLK);
        if (RST || man_en) begin
            pend = 0; rdy_cnt = -1; r_ready = 1'b0; r_rvalid = 1'b0;
        end else begin
            r_rvalid = 1'b0;
            if (pend) begin
                if (rv_cnt == 0) begin
                    r_rvalid = 1'b1; r_rdata = rv_data; pend = 0;
                end else rv_cnt--;
            end else if ($urandom_range(0, 3) == 0) begin
                r_rvalid = 1'b1; r_rdata = $urandom;
            end
            r_ready = 1'b0;
            if (mem_req) begin
                if (rdy_cnt < 0) rdy_cnt = (cfg_rdy < 0) ? int'($urandom_range(0, 3)) : cfg_rdy;
                if (rdy_cnt == 0) begin
                    r_ready = 1'b1; rdy_cnt = -1;
                    if (mem_we) dmem[mem_addr] = mem_wdata;
                    else begin
                        pend = 1; rv_data = dmem[mem_addr];
                        rv_cnt = (cfg_rv < 0) ? int'($urandom_range(0, 3)) : cfg_rv;
                    end
                end else rdy_cnt--;
            end else begin
                r_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: checks requests against the expected queue and the halt entry
    mem_t  mon_e;
    halt_t mon_h;
    bit    prev_halted = 0;
    always begin
        @(negedge CLK);
        #1;
        if (RST) prev_halted = 0;
        else begin
            if (mem_req) begin
                if (exp_mem.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_req: actual addr=0x%0h we=%0b required no request", mem_addr, mem_we);
                end else begin
                    mon_e = exp_mem[0];
                    chk("req_we", mem_we, mon_e.we);
                    chk("req_addr", mem_addr, mon_e.addr);
                    chk("req_wdata", mem_wdata, mon_e.wdata);
                    if (mem_ready) void'(exp_mem.pop_front());
                end
            end
            if (prev_halted) chk("exit_pulse_once", exit_pulse, 0);
            if (exit_pulse) begin
                if (exp_halt.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_exit: actual pc=0x%0h required no exit", instr_addr);
                end else begin
                    mon_h = exp_halt.pop_front();
                    chk("exit_acc", acc, mon_h.acc);
                    chk("exit_pc", instr_addr, mon_h.pc);
                    chk("exit_halted", halted, 1);
                end
            end
            prev_halted = halted;
        end
    end

    function automatic logic [15:0] ins(input logic [7:0] op, input logic [7:0] im);
        return {op, im};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) prog[i] = '0;
        for (int i = 0; i < 256; i++) dmem[i] = $urandom;
    endtask

    task automatic wait_halt_and_check(input string nm);
        int cyc = 0;
        while (!halted && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        if (!halted) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: actual halted=0 required halted=1 within 2000 cycles", nm);
        end
        repeat (4) @(negedge CLK);
        #2;
        chk({nm, "_acc"}, acc, m_acc);
        chk({nm, "_pc"}, instr_addr, m_pc);
        chk({nm, "_halted"}, halted, 1);
        chk({nm, "_req_idle"}, mem_req, 0);
        chk({nm, "_memq_left"}, exp_mem.size(), 0);
        chk({nm, "_haltq_left"}, exp_halt.size(), 0);
    endtask

    task automatic run_test(input string nm, input int rdy, input int rv);
        @(negedge CLK);
        RST = 1'b1;
        cfg_rdy = rdy; cfg_rv = rv;
        model_run();
        #1;
        chk("rst_acc", acc, 0);
        chk("rst_pc", instr_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_exit", exit_pulse, 0);
        @(negedge CLK);
        RST = 1'b0;
        wait_halt_and_check(nm);
    endtask

    task automatic reset_mid_test();
        int cyc = 0;
        clear_mem();
        prog[0] = ins(8'h08, 8'h05);
        prog[1] = ins(8'h01, 8'h20);
        prog[2] = ins(8'h13, 8'h00);
        @(negedge CLK);
        RST = 1'b1; man_en = 1'b1; man_ready = 1'b0; man_rvalid = 1'b0;
        model_run();
        @(negedge CLK);
        RST = 1'b0;
        while (!mem_req && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        if (!mem_req) begin
            n_cmp++; n_bad++;
            $display("FAIL rstmid_no_req: actual mem_req=0 required mem_req=1");
        end
        man_ready = 1'b1;
        @(negedge CLK);
        man_ready = 1'b0;
        @(negedge CLK);
        #1;
        chk("rstmid_wait_acc", acc, 5);
        chk("rstmid_wait_req", mem_req, 0);
        #3;
        RST = 1'b1;
        #1;
        chk("rstmid_req", mem_req, 0);
        chk("rstmid_acc", acc, 0);
        chk("rstmid_pc", instr_addr, 0);
        man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
        model_run();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        man_rvalid = 1'b0;
        man_en = 1'b0;
        wait_halt_and_check("rstmid_rerun");
    endtask

    task automatic gen_random();
        logic [7:0] ops [21] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11,
                                 8'h12, 8'h14, 8'h3C};
        logic [7:0] op;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 9) == 0) op = 8'h13;
            else if ($urandom_range(0, 15) == 0) op = 8'($urandom_range(21, 255));
            else op = ops[$urandom_range(0, 20)];
            prog[i] = ins(op, 8'($urandom));
        end
    endtask

    initial begin
        clear_mem();
        prog[0] = ins(8'h08, 8'h7A); prog[1] = ins(8'h02, 8'h01); prog[2] = ins(8'h13, 8'h00);
        run_test("ldi_addi_exit", 0, 0);

        clear_mem();
        prog[0] = ins(8'h08, 8'h05); prog[1] = ins(8'h09, 8'h10); prog[2] = ins(8'h13, 8'h00);
        run_test("st_wait3", 3, 0);

        clear_mem();
        dmem[8'h20] = 32'hFFFF_FFFF;
        prog[0] = ins(8'h08, 8'h01); prog[1] = ins(8'h01, 8'h20); prog[2] = ins(8'h11, 8'h08);
        prog[3] = ins(8'h13, 8'h00); prog[8] = ins(8'h13, 8'h00);
        run_test("add_wrap_bez", 0, 2);

        clear_mem();
        prog[0] = ins(8'h14, 8'h10); prog[1] = ins(8'h10, 8'h04); prog[4] = ins(8'h08, 8'h80);
        prog[5] = ins(8'h05, 8'h18); prog[6] = ins(8'h14, 8'h3F); prog[63] = ins(8'h00, 8'h00);
        prog[16] = ins(8'h13, 8'h00);
        run_test("shl_blz_wrap", -1, -1);

        clear_mem();
        prog[0] = ins(8'h04, 8'h01); prog[1] = ins(8'h12, 8'h04); prog[4] = ins(8'h3C, 8'h55);
        prog[5] = ins(8'h13, 8'h00);
        run_test("subi_bnz_undef", -1, -1);

        reset_mid_test();

        for (int t = 0; t < 25; t++) begin
            clear_mem();
            for (int tries = 0; tries < 100; tries++) begin
                gen_random();
                model_run();
                if (m_ok) break;
            end
            if (m_ok) run_test("random", -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/acc_controller_param.md
Name: acc_controller_param

Overview:
Parametrised accumulator controller, next generation of the single-accumulator sequencer. Fetches 16-bit-class instructions from external program memory by PC, executes ALU/branch ops on a DATA_W accumulator, and accesses data memory through a req/ready + rvalid handshake with arbitrary wait states. Adds HALT, a branch-if-negative op, and a configurable shift width.

Parameters:
DATA_W, 32, accumulator and data-memory word width (>=8)
PC_W, 6, program counter width; program memory depth 2^PC_W
IMM_W, 8, immediate / data-address field width; instruction width = 8+IMM_W
SH_W, 5, shift-amount bits taken from instr[SH_W-1:0] (<= IMM_W)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
instr_addr  out  PC_W  current PC
instr_data  in  8+IMM_W  instruction at instr_addr, valid combinationally same cycle; opcode=[8+IMM_W-1:IMM_W], imm=[IMM_W-1:0]
mem_req  out  1  data-memory request
mem_we  out  1  1=store, 0=load; valid with mem_req
mem_addr  out  IMM_W  data address (imm field)
mem_wdata  out  DATA_W  store data (accumulator)
mem_ready  in  1  request accepted when mem_req&mem_ready
mem_rvalid  in  1  load data valid
mem_rdata  in  DATA_W  load data
acc  out  DATA_W  accumulator
halted  out  1  high in HALT state
exit_pulse  out  1  one-cycle pulse on entry to HALT

Behaviour:
- States: EXEC, MEM_REQ, MEM_WAIT, HALT. RST (async): state=EXEC, PC=0, acc=0, mem_req=0, mem_we=0, halted=0, exit_pulse=0, latched opcode/imm=0.
- EXEC: decode instr_data, one cycle per non-memory op; PC<=PC+1 unless branch taken. PC wraps 2^PC_W-1 -> 0.
- Opcodes (imm zero-extended to DATA_W, arithmetic mod 2^DATA_W):
  0x02 ADDI, 0x04 SUBI, 0x08 LDI (acc<=imm), 0x0B ANDI, 0x0D ORI, 0x0F XORI;
  0x05 SHL / 0x06 SHR logical by instr[SH_W-1:0];
  0x10 JMP PC<=imm[PC_W-1:0]; 0x11 BEZ taken if acc==0; 0x12 BNZ taken if acc!=0; 0x14 BLZ taken if acc[DATA_W-1]==1;
  0x13 EXIT -> HALT, PC unchanged, exit_pulse=1 next cycle only;
  memory ops 0x01 ADD, 0x03 SUB, 0x07 LD, 0x0A AND, 0x0C OR, 0x0E XOR, 0x09 ST: latch opcode+imm, go MEM_REQ, PC unchanged;
  0x00 and all undefined opcodes: NOP (PC+1).
- MEM_REQ: mem_req=1, mem_addr=latched imm, mem_we=(op==ST), mem_wdata=acc; held stable until mem_ready. On accept: ST -> PC+1, EXEC; loads -> MEM_WAIT. mem_req deasserts the cycle after accept.
- MEM_WAIT: mem_req=0; waits indefinitely. On mem_rvalid: acc<=acc op mem_rdata (LD: acc<=mem_rdata), PC+1, EXEC. mem_rvalid outside MEM_WAIT ignored.
- HALT: no requests, PC/acc frozen, halted=1; exits only via RST.
- RST mid-transaction: request dropped immediately (async); pending rvalid after reset ignored.
- acc, instr_addr, halted are direct register outputs (no combinational path from inputs).

Test Plan:
- Reset then LDI 0x7A, ADDI 0x01, EXIT -> acc=0x7B after 2 EXEC cycles, exit_pulse one cycle, halted=1, PC stays 2.
- LDI 0x05; ST 0x10 with mem_ready low 3 cycles -> mem_req,mem_we=1,addr=0x10,wdata=5 stable 4 cycles; PC advances only after accept.
- ADD 0x20 with rvalid 2 cycles after accept, rdata=0xFFFFFFFF, acc=1 -> acc=0 (wrap), next BEZ taken to imm target.
- LDI 0x80, SHL 24 -> acc=0x80000000; BLZ 0x3F taken -> PC=63; NOP at 63 -> PC wraps to 0.
- SUBI 1 from acc=0 -> acc=0xFFFFFFFF; BNZ taken; undefined opcode 0x3C -> NOP, PC+1, acc unchanged.
- RST asserted during MEM_WAIT -> mem_req/acc/PC zero immediately; late rvalid ignored; execution restarts at PC=0.
